// File: rtl/bit_serial_alu_seq.sv
// Multi-bit AND/OR/ADD/SUB/SLT built by stepping one single-bit ALU over the operands, LSB first.
// One bit per clock; the ripple carry lives in a flop between bit cycles.

module one_bit_alu (
  input  logic       a,
  input  logic       b,
  input  logic       carry_in,
  input  logic       binvert,
  input  logic [1:0] operation,
  output logic       result,
  output logic       carry_out
);
  logic bb;

  always_comb begin
    bb        = b ^ binvert;
    carry_out = (a & bb) | (a & carry_in) | (bb & carry_in);
    case (operation)
      2'b00:   result = a & bb;
      2'b01:   result = a | bb;
      2'b10:   result = a ^ bb ^ carry_in;
      default: result = 1'b0;
    endcase
  end
endmodule

// state | meaning
// IDLE  | waiting for start; result/flags hold the last completed operation
// RUN   | one operand bit per cycle through the single-bit ALU
// DONE  | one-cycle done pulse, result/flags valid
module bit_serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] res_sh;
  logic [2:0]       op_r;
  logic             cry;
  logic [CW-1:0]    bit_cnt;

  logic             is_sub, is_arith, alu_res, alu_cout, last_v;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] shifted, fin_res;

  always_comb begin
    is_sub   = (op_r == 3'd3) || (op_r == 3'd4);
    is_arith = (op_r == 3'd2) || is_sub;
    case (op_r)
      3'd1:             alu_op = 2'b01;
      3'd2, 3'd3, 3'd4: alu_op = 2'b10;
      default:          alu_op = 2'b00;
    endcase
  end

  one_bit_alu u_alu (
    .a         (a_sh[0]),
    .b         (b_sh[0]),
    .carry_in  (cry),
    .binvert   (is_sub),
    .operation (alu_op),
    .result    (alu_res),
    .carry_out (alu_cout)
  );

  // On the last bit, alu_res is the sign of the sum/difference and cry is the carry into the MSB.
  always_comb begin
    shifted = {alu_res, res_sh};
    last_v  = cry ^ alu_cout;
    if (op_r == 3'd4)
      fin_res = {{(WIDTH-1){1'b0}}, alu_res ^ last_v};
    else
      fin_res = shifted;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      op_r      <= '0;
      cry       <= 1'b0;
      bit_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            op_r    <= op;
            cry     <= (op == 3'd3) || (op == 3'd4);
            bit_cnt <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          res_sh  <= shifted[WIDTH-1:1];
          cry     <= alu_cout;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CW'(WIDTH-1)) begin
            result    <= fin_res;
            zero      <= (fin_res == '0);
            carry_out <= is_arith & alu_cout;
            overflow  <= is_arith & last_v;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Directed bench for bit_serial_alu_seq at WIDTH=8: latency, arithmetic/logic results, flags, reset abort.

module tb_bit_serial_alu_seq;
  logic       clk = 1'b0;
  logic       rst, start;
  logic [2:0] op;
  logic [7:0] a, b;
  logic       busy, done, carry_out, overflow, zero;
  logic [7:0] result;

  int errors = 0;
  int checks = 0;

  bit_serial_alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and follow it for 14 edges; edge 1 is the accepting edge.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] er, input logic ec, input logic ev, input logic ez,
                        input bit midstart);
    int busy_cnt, done_cnt, done_at;
    logic [7:0] r_res;
    logic r_c, r_v, r_z;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    r_res = 'x; r_c = 'x; r_v = 'x; r_z = 'x;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = e;
          r_res = result; r_c = carry_out; r_v = overflow; r_z = zero;
        end
      end
      if (midstart && e == 3) begin
        start = 1'b1; op = 3'd1; a = ~x; b = ~y;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk({tag, ".busy_cycles"}, busy_cnt, 8);
    chk({tag, ".done_edge"}, done_at, 9);
    chk({tag, ".done_count"}, done_cnt, 1);
    chk({tag, ".result"}, r_res, er);
    chk({tag, ".carry_out"}, r_c, ec);
    chk({tag, ".overflow"}, r_v, ev);
    chk({tag, ".zero"}, r_z, ez);
    chk({tag, ".result_hold"}, result, er);
  endtask

  initial begin
    int seen_done;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.result", result, 8'h00);
    chk("reset.carry_out", carry_out, 0);
    chk("reset.overflow", overflow, 0);
    chk("reset.zero", zero, 1);

    run_op("add_0f_01", 3'd2, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("add_7f_01", 3'd2, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("add_ff_01", 3'd2, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    run_op("sub_05_07", 3'd3, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("slt_05_07", 3'd4, 8'h05, 8'h07, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("slt_80_7f", 3'd4, 8'h80, 8'h7F, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("and_cc_aa", 3'd0, 8'hCC, 8'hAA, 8'h88, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("or_cc_aa",  3'd1, 8'hCC, 8'hAA, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op("op7_as_and", 3'd7, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("sub_10_10", 3'd3, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

    // Reset asserted during the 4th RUN cycle aborts the operation.
    @(negedge clk);
    op = 3'd2; a = 8'h12; b = 8'h34; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    seen_done = 0;
    @(posedge clk); #1;
    chk("rst_mid.busy", busy, 0);
    chk("rst_mid.result", result, 8'h00);
    chk("rst_mid.zero", zero, 1);
    rst = 1'b0;
    for (int e = 0; e < 10; e++) begin
      if (done) seen_done++;
      @(posedge clk); #1;
    end
    chk("rst_mid.no_done", seen_done, 0);

    // Start immediately after reset release.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    run_op("after_rst_add", 3'd2, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
